edge_event_unit: RTL and testbench
==================================

# edge_event_unit

Multi-channel, parametrised successor to the single-stage edge detector. Each channel synchronises an asynchronous input and rejects glitches with a stability filter. It then produces one-cycle rising and falling pulses and gates them through a per-channel mode. Qualified events are latched into sticky pending flags and saturating counters. The block feeds the interrupt/status logic for GPIO-style inputs.

## Interface
- WIDTH, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥1)
- FILTER_CYCLES, 4: consecutive cycles a new synchronised value must persist before it is accepted (≥1; 1 = no filtering)
- CNT_WIDTH, 8: width of each per-channel event counter (≥1)
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- signal  input  WIDTH  raw, asynchronous channel inputs
- mode  input  2*WIDTH  per-channel edge select, channel i at bits [2i+1:2i]; 00 off, 01 rising, 10 falling, 11 both
- clr  input  WIDTH  per-channel clear of pending flag and counter, level-sensitive, sampled each cycle
- level  output  WIDTH  filtered, debounced level
- pos_edge  output  WIDTH  one-cycle pulse on filtered rising edge, independent of mode
- neg_edge  output  WIDTH  one-cycle pulse on filtered falling edge, independent of mode
- event  output  WIDTH  pos_edge/neg_edge gated by mode
- pending  output  WIDTH  sticky event flags
- count  output  WIDTH*CNT_WIDTH  saturating event counters, channel i at [CNT_WIDTH*(i+1)-1 : CNT_WIDTH*i]
- irq  output  1  OR of all pending bits

## Operation
- Sync: signal[i] passes through a SYNC_STAGES-deep flop chain. Its last stage is sync_out[i].
- Filter, per channel: a counter fcnt of width max(1, $clog2(FILTER_CYCLES)) and a register level.
  - If sync_out == level: fcnt <= 0.
  - Else if fcnt == FILTER_CYCLES-1: level <= sync_out and fcnt <= 0.
  - Else: fcnt <= fcnt+1.
- Edge: level_d <= level. pos_edge = level & ~level_d. neg_edge = ~level & level_d. Both are decoded from registers only.
- event[i] = (mode[2i] & pos_edge[i]) | (mode[2i+1] & neg_edge[i]). A mode change takes effect in the same cycle and never disturbs filter state.
- pending[i]: set on event[i], cleared by clr[i]. If event and clr occur in the same cycle, set wins.
- count[i]: increments on event[i] and saturates at all-ones.
  - clr[i] alone gives 0.
  - clr[i] together with event[i] gives 1.
- irq = |pending.

## Timing
- Reset values: all sync flops, fcnt, level, level_d, pending and count are 0. Hence level, pos_edge, neg_edge, event, pending, count and irq are all 0.
- Latency: after an input change is set up before edge 0 and held, level changes at edge SYNC_STAGES+FILTER_CYCLES-1. The pos_edge/neg_edge/event pulse is high from that edge to the next. pending and count update at the following edge.
- Glitch rejection: a change that persists at sync_out for fewer than FILTER_CYCLES cycles produces no level change. fcnt returns to 0 when sync_out reverts.
- An input that is already high when reset is released produces a pos_edge after the normal latency.
- Each pulse is exactly one cycle wide. Opposite edges on the same channel are separated by at least FILTER_CYCLES cycles.
- Asserting n_rst mid-filter or mid-pulse immediately clears all state, with no pulse emitted.
- Channels are fully independent. Simultaneous events on any channels are all captured.

## Structure
- Package edge_event_pkg holds the mode typedef enum logic [1:0] {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH}.
- Sub-module edge_filter_chan (sync chain, filter, level/level_d, pos/neg/event, pending and counter for one channel) is generated WIDTH times. The top level only slices mode/count and ORs pending into irq.

## Test plan
- Reset, then signal[0] 0→1 held, SYNC_STAGES=2, FILTER_CYCLES=4, mode=01 → level[0] rises at edge 5, pos_edge/event[0] high for exactly one cycle, pending[0]=1 and count[0]=1 from edge 6, irq=1.
- 3-cycle high glitch on signal[1] → level[1], pos_edge[1] and neg_edge[1] stay 0, count unchanged.
- mode=10 on channel 2, full 0→1→0 pulse of 10 cycles → only neg_edge produces an event, count[2]=1. Switch mode to 11 and repeat → count[2]=3.
- 300 qualifying edges with CNT_WIDTH=8 → count saturates at 255. Then clr asserted in the same cycle as an event → pending stays 1, count=1.
- signal high during reset, then n_rst deasserted → single pos_edge after 6 cycles. Assert n_rst mid-filter on another channel → all outputs 0 immediately, no pulse afterwards.

Source files
------------

// File: rtl/edge_event_pkg.sv
// Shared definitions for the edge event unit.
//   edge_mode_t  : per-channel edge select (off / rising / falling / both)
//   qualify_edge : gates the raw rising/falling pulses of a channel by its mode
package edge_event_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  function automatic logic qualify_edge(input edge_mode_t mode,
                                        input logic       pos,
                                        input logic       neg);
    logic q;
    case (mode)
      EDGE_OFF:  q = 1'b0;
      EDGE_RISE: q = pos;
      EDGE_FALL: q = neg;
      EDGE_BOTH: q = pos | neg;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/edge_filter_chan.sv
// One channel of the edge event unit: synchroniser chain, stability filter,
// filtered level with one-cycle rising/falling pulses, mode gating, sticky
// pending flag and saturating event counter.
// Ports:
//   i_clk, i_n_rst : clock, asynchronous active-low reset
//   i_signal       : raw asynchronous input
//   i_mode         : edge select for this channel
//   i_clr          : level-sensitive clear of pending flag and counter
//   o_level        : filtered level
//   o_pos_edge     : one-cycle pulse on filtered rising edge
//   o_neg_edge     : one-cycle pulse on filtered falling edge
//   o_event        : pulses gated by i_mode
//   o_pending      : sticky event flag
//   o_count        : saturating event counter
module edge_filter_chan
  import edge_event_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_n_rst,
  input  logic                 i_signal,
  input  edge_mode_t           i_mode,
  input  logic                 i_clr,
  output logic                 o_level,
  output logic                 o_pos_edge,
  output logic                 o_neg_edge,
  output logic                 o_event,
  output logic                 o_pending,
  output logic [CNT_WIDTH-1:0] o_count
);

  localparam int FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FCNT_W-1:0]    FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);
  localparam logic [FCNT_W-1:0]    FCNT_ONE  = FCNT_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   w_chain;
  logic                   w_sync_out;
  logic [FCNT_W-1:0]      r_fcnt;
  logic                   r_level;
  logic                   r_level_d;
  logic                   w_pos;
  logic                   w_neg;
  logic                   w_event;
  logic                   r_pending;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   w_count_nxt;

  // Appending the raw input below the chain gives the shifted value for any depth, including 1.
  assign w_chain    = {r_sync, i_signal};
  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Synchroniser shift register.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= w_chain[SYNC_STAGES-1:0];
    end
  end

  // Stability filter: a new value must persist FILTER_CYCLES cycles; any revert restarts the count.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_fcnt  <= '0;
      r_level <= 1'b0;
    end else if (w_sync_out == r_level) begin
      r_fcnt  <= '0;
    end else if (r_fcnt == FCNT_LAST) begin
      r_level <= w_sync_out;
      r_fcnt  <= '0;
    end else begin
      r_fcnt  <= r_fcnt + FCNT_ONE;
    end
  end

  // Delayed level for edge decode.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  // Edge pulses come from registers only, so they are glitch-free.
  assign w_pos   = r_level & ~r_level_d;
  assign w_neg   = ~r_level & r_level_d;
  assign w_event = qualify_edge(i_mode, w_pos, w_neg);

  // Sticky pending flag; a new event outranks a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_pending <= 1'b0;
    end else if (w_event) begin
      r_pending <= 1'b1;
    end else if (i_clr) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= r_pending;
    end
  end

  // Next counter value: clear restarts at 1 if an event coincides, otherwise saturating increment.
  always_comb begin
    w_count_nxt = r_count;
    if (i_clr) begin
      w_count_nxt = w_event ? CNT_ONE : '0;
    end else if (w_event && (r_count != CNT_MAX)) begin
      w_count_nxt = r_count + CNT_ONE;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Event counter register.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_level    = r_level;
  assign o_pos_edge = w_pos;
  assign o_neg_edge = w_neg;
  assign o_event    = w_event;
  assign o_pending  = r_pending;
  assign o_count    = r_count;

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit for GPIO-style inputs. Each channel is an
// independent edge_filter_chan; this level only slices mode/count and ORs
// the pending flags into a single interrupt.
// Ports:
//   i_clk, i_n_rst : clock, asynchronous active-low reset
//   i_signal  [WIDTH]           raw asynchronous inputs
//   i_mode    [2*WIDTH]         per-channel mode, channel i at [2i+1:2i]
//   i_clr     [WIDTH]           per-channel clear of pending and counter
//   o_level, o_pos_edge, o_neg_edge, o_event, o_pending [WIDTH]
//   o_count   [WIDTH*CNT_WIDTH] per-channel counters, channel i at [CNT_WIDTH*i +: CNT_WIDTH]
//   o_irq                       OR of all pending flags
module edge_event_unit
  import edge_event_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_n_rst,
  input  logic [WIDTH-1:0]           i_signal,
  input  logic [2*WIDTH-1:0]         i_mode,
  input  logic [WIDTH-1:0]           i_clr,
  output logic [WIDTH-1:0]           o_level,
  output logic [WIDTH-1:0]           o_pos_edge,
  output logic [WIDTH-1:0]           o_neg_edge,
  output logic [WIDTH-1:0]           o_event,
  output logic [WIDTH-1:0]           o_pending,
  output logic [WIDTH*CNT_WIDTH-1:0] o_count,
  output logic                       o_irq
);

  logic [WIDTH-1:0] w_pending;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    edge_filter_chan #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .CNT_WIDTH     (CNT_WIDTH)
    ) u_chan (
      .i_clk      (i_clk),
      .i_n_rst    (i_n_rst),
      .i_signal   (i_signal[g]),
      .i_mode     (edge_mode_t'(i_mode[2*g +: 2])),
      .i_clr      (i_clr[g]),
      .o_level    (o_level[g]),
      .o_pos_edge (o_pos_edge[g]),
      .o_neg_edge (o_neg_edge[g]),
      .o_event    (o_event[g]),
      .o_pending  (w_pending[g]),
      .o_count    (o_count[CNT_WIDTH*g +: CNT_WIDTH])
    );
  end

  assign o_pending = w_pending;
  assign o_irq     = |w_pending;

endmodule

// File: tb/tb_edge_event_unit.sv
// Directed test of edge_event_unit (WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=4, CNT_WIDTH=8).
module tb_edge_event_unit;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  sig;
  logic [7:0]  mode;
  logic [3:0]  clr;
  logic [3:0]  level, pos_edge, neg_edge, evt, pending;
  logic [31:0] count;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  int pos_n, neg_n, ev_n, pos_at, neg_at;
  logic [3:0] seen;

  edge_event_unit #(
    .WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_WIDTH(8)
  ) dut (
    .i_clk      (clk),
    .i_n_rst    (n_rst),
    .i_signal   (sig),
    .i_mode     (mode),
    .i_clr      (clr),
    .o_level    (level),
    .o_pos_edge (pos_edge),
    .o_neg_edge (neg_edge),
    .o_event    (evt),
    .o_pending  (pending),
    .o_count    (count),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   {28'd0, level},    32'd0);
    chk({tag, "_edges"},   {24'd0, pos_edge, neg_edge}, 32'd0);
    chk({tag, "_event"},   {28'd0, evt},      32'd0);
    chk({tag, "_pending"}, {27'd0, irq, pending}, 32'd0);
    chk({tag, "_count"},   count,             32'd0);
  endtask

  // Drive a high pulse of 'hold' cycles on channel ch and record pulse counts/positions
  // (index i = edges elapsed since the input changed, starting at edge 0).
  task automatic pulse_ch(input int ch, input int hold);
    pos_n = 0; neg_n = 0; ev_n = 0; pos_at = -1; neg_at = -1;
    sig[ch] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == hold) sig[ch] = 1'b0;
      tick(1);
      if (pos_edge[ch]) begin pos_n++; pos_at = i; end
      if (neg_edge[ch]) begin neg_n++; neg_at = i; end
      if (evt[ch]) ev_n++;
    end
  endtask

  initial begin
    n_rst = 1'b0; sig = 4'd0; mode = 8'd0; clr = 4'd0;

    // Reset state
    tick(2);
    chk_all_zero("reset");
    n_rst = 1'b1;
    tick(2);
    chk_all_zero("post_reset");

    // Channel 0 rising edge with mode 01: level at edge 5, pending/count at edge 6
    mode = 8'b00_00_00_01;
    sig[0] = 1'b1;
    tick(5);
    chk("ch0_level_before", {31'd0, level[0]}, 32'd0);
    tick(1);
    chk("ch0_level_edge5", {28'd0, level}, 32'h1);
    chk("ch0_pos_edge5",   {28'd0, pos_edge}, 32'h1);
    chk("ch0_event_edge5", {28'd0, evt}, 32'h1);
    chk("ch0_pend_edge5",  {28'd0, pending}, 32'h0);
    tick(1);
    chk("ch0_pos_width",   {28'd0, pos_edge}, 32'h0);
    chk("ch0_event_width", {28'd0, evt}, 32'h0);
    chk("ch0_pending",     {28'd0, pending}, 32'h1);
    chk("ch0_count",       count, 32'h0000_0001);
    chk("ch0_irq",         {31'd0, irq}, 32'h1);

    // 3-cycle glitch on channel 1 is rejected
    mode = 8'b00_00_01_01;
    seen = 4'd0;
    sig[1] = 1'b1;
    tick(3);
    sig[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | {2'b00, pos_edge[1] | neg_edge[1], level[1]};
    end
    chk("glitch_activity", {28'd0, seen}, 32'h0);
    chk("glitch_count",    {24'd0, count[15:8]}, 32'h0);
    chk("glitch_pending",  {28'd0, pending}, 32'h1);

    // Channel 2 falling-only mode, 10-cycle pulse
    mode = 8'b00_10_01_01;
    pulse_ch(2, 10);
    chk("ch2f_pos_n",  pos_n,  32'd1);
    chk("ch2f_pos_at", pos_at, 32'd5);
    chk("ch2f_neg_n",  neg_n,  32'd1);
    chk("ch2f_neg_at", neg_at, 32'd15);
    chk("ch2f_ev_n",   ev_n,   32'd1);
    chk("ch2f_count",  {24'd0, count[23:16]}, 32'd1);
    chk("ch2f_pend",   {28'd0, pending}, 32'h5);

    // Same pulse with both edges selected
    mode = 8'b00_11_01_01;
    pulse_ch(2, 10);
    chk("ch2b_ev_n",  ev_n, 32'd2);
    chk("ch2b_count", {24'd0, count[23:16]}, 32'd3);

    // Clear alone zeroes channel 2 and leaves others untouched
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    chk("ch2_clr_count", {24'd0, count[23:16]}, 32'd0);
    chk("ch2_clr_pend",  {28'd0, pending}, 32'h1);
    chk("ch0_kept",      {24'd0, count[7:0]}, 32'd1);

    // Channel 3, both edges: 200 events then saturation at 255 after 300
    mode = 8'b11_00_01_01;
    repeat (100) begin
      sig[3] = 1'b1; tick(6);
      sig[3] = 1'b0; tick(6);
    end
    tick(3);
    chk("ch3_count_200", {24'd0, count[31:24]}, 32'd200);
    repeat (50) begin
      sig[3] = 1'b1; tick(6);
      sig[3] = 1'b0; tick(6);
    end
    tick(3);
    chk("ch3_count_sat", {24'd0, count[31:24]}, 32'd255);
    chk("ch3_pending",   {31'd0, pending[3]}, 32'd1);

    // Clear coinciding with an event: pending stays set, count becomes 1
    sig[3] = 1'b1;
    tick(6);
    chk("ch3_event_now", {31'd0, evt[3]}, 32'd1);
    clr[3] = 1'b1;
    tick(1);
    clr[3] = 1'b0;
    chk("ch3_clr_ev_pend",  {31'd0, pending[3]}, 32'd1);
    chk("ch3_clr_ev_count", {24'd0, count[31:24]}, 32'd1);
    tick(1);
    chk("ch3_count_hold", {24'd0, count[31:24]}, 32'd1);

    // Input already high during reset: one pos_edge after normal latency
    n_rst = 1'b0;
    sig = 4'b0001;
    mode = 8'b00_00_01_01;
    #1;
    chk_all_zero("rst_async");
    tick(2);
    chk_all_zero("rst_hold");
    n_rst = 1'b1;
    tick(5);
    chk("rsthi_pos_early", {28'd0, pos_edge}, 32'h0);
    tick(1);
    chk("rsthi_pos", {28'd0, pos_edge}, 32'h1);
    tick(1);
    chk("rsthi_pos_width", {28'd0, pos_edge}, 32'h0);
    chk("rsthi_count", count, 32'h0000_0001);

    // Reset mid-filter on channel 1: everything clears, no later pulse
    sig[1] = 1'b1;
    tick(3);
    n_rst = 1'b0;
    #1;
    chk_all_zero("midflt_rst");
    sig = 4'b0000;
    tick(2);
    n_rst = 1'b1;
    seen = 4'd0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      seen = seen | {pos_edge[1] | pos_edge[0], neg_edge[1] | neg_edge[0], evt[1] | evt[0], irq};
    end
    chk("midflt_no_pulse", {28'd0, seen}, 32'h0);
    chk_all_zero("midflt_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
